// File: rtl/sevenseg_scan4_if.sv
// Pin bundle between the BCD source and the 4-digit 7-segment scanner.
interface sevenseg_scan4_if;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] C;
  logic [3:0] D;
  logic [3:0] dp_in;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  logic       frame_tick;

  modport master (output A, B, C, D, dp_in, input seg, an, dp, frame_tick);
  modport slave  (input A, B, C, D, dp_in, output seg, an, dp, frame_tick);
endinterface

// File: rtl/sevenseg_scan4.sv
// Frame-coherent 4-digit common-anode 7-segment scanner with inter-digit blanking.
// Optional leading-zero suppression on A..C: define LEADING_ZERO_BLANK_EN.
module sevenseg_scan4 #(
  parameter int unsigned PRESCALE     = 2000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  sevenseg_scan4_if.slave   bus
);

  localparam int unsigned    CW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0]  LAST    = CW'(PRESCALE - 1);
  localparam logic [CW-1:0]  BLANK_C = CW'(BLANK_CYCLES);

  typedef enum logic [1:0] {DIG_A = 2'd0, DIG_B = 2'd1, DIG_C = 2'd2, DIG_D = 2'd3} dig_t;

  dig_t          dig, dig_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [3:0]    sh_a, sh_b, sh_c, sh_d, sh_dp;
  logic [6:0]    seg_next;
  logic [3:0]    an_next, an_sel, cur;
  logic          dp_next, tick_next, slot_end, lit, blanked, cur_dp;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  always_comb begin
    slot_end  = (cnt == LAST);
    cnt_next  = slot_end ? '0 : cnt + 1'b1;
    dig_next  = dig;
    tick_next = slot_end && (dig == DIG_D);
    cur       = sh_a;
    cur_dp    = sh_dp[3];
    an_sel    = 4'b0111;
    blanked   = 1'b0;
    case (dig)
      DIG_A: begin
        cur = sh_a; cur_dp = sh_dp[3]; an_sel = 4'b0111;
        if (slot_end) dig_next = DIG_B;
      end
      DIG_B: begin
        cur = sh_b; cur_dp = sh_dp[2]; an_sel = 4'b1011;
        if (slot_end) dig_next = DIG_C;
      end
      DIG_C: begin
        cur = sh_c; cur_dp = sh_dp[1]; an_sel = 4'b1101;
        if (slot_end) dig_next = DIG_D;
      end
      default: begin
        cur = sh_d; cur_dp = sh_dp[0]; an_sel = 4'b1110;
        if (slot_end) dig_next = DIG_A;
      end
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    // A digit is suppressed only while it and everything to its left are zero.
    case (dig)
      DIG_A:   blanked = (sh_a == 4'd0);
      DIG_B:   blanked = (sh_a == 4'd0) && (sh_b == 4'd0);
      DIG_C:   blanked = (sh_a == 4'd0) && (sh_b == 4'd0) && (sh_c == 4'd0);
      default: blanked = 1'b0;
    endcase
`else
    blanked = 1'b0;
`endif
    lit      = (cnt >= BLANK_C) && !blanked;
    seg_next = '1;
    an_next  = '1;
    dp_next  = 1'b1;
    if (lit) begin
      seg_next = decode(cur);
      an_next  = an_sel;
      dp_next  = ~cur_dp;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt            <= '0;
      dig            <= DIG_A;
      sh_a           <= '0;
      sh_b           <= '0;
      sh_c           <= '0;
      sh_d           <= '0;
      sh_dp          <= '0;
      bus.seg        <= '1;
      bus.an         <= '1;
      bus.dp         <= 1'b1;
      bus.frame_tick <= 1'b0;
    end else begin
      cnt            <= cnt_next;
      dig            <= dig_next;
      bus.seg        <= seg_next;
      bus.an         <= an_next;
      bus.dp         <= dp_next;
      bus.frame_tick <= tick_next;
      // Last edge of the frame: the outgoing D output still uses the old shadow.
      if (tick_next) begin
        sh_a  <= bus.A;
        sh_b  <= bus.B;
        sh_c  <= bus.C;
        sh_d  <= bus.D;
        sh_dp <= bus.dp_in;
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan4.sv
// Scoreboard bench for sevenseg_scan4 (PRESCALE=8, BLANK_CYCLES=2).
module tb_sevenseg_scan4;

  localparam int PRESCALE = 8;
  localparam int BLANK    = 2;
  localparam logic [12:0] OFF_OUT = {1'b0, 4'hF, 7'h7F, 1'b1};
  localparam logic [6:0] SEG_T [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
    7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};

  logic clk = 1'b0;
  logic rst = 1'b0;
  sevenseg_scan4_if bus();

  sevenseg_scan4 #(.PRESCALE(PRESCALE), .BLANK_CYCLES(BLANK)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          edge_no = 0;
  logic [3:0]  msh [4];
  logic [3:0]  mdp;
  logic [12:0] exp_q [$];

  // Reference: expected {frame_tick, an, seg, dp} right after the current edge.
  function automatic logic [12:0] model_edge();
    logic [12:0] r;
    int p, d;
    bit zl;
    if (!rst) begin
      edge_no = 0;
      for (int i = 0; i < 4; i++) msh[i] = 4'd0;
      mdp = 4'd0;
      return OFF_OUT;
    end
    edge_no++;
    p  = (edge_no - 1) % PRESCALE;
    d  = ((edge_no - 1) / PRESCALE) % 4;
    zl = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    zl = (d < 3);
    for (int i = 0; i <= d && i < 3; i++) if (msh[i] != 4'd0) zl = 1'b0;
`endif
    if (p < BLANK || zl) r = OFF_OUT;
    else r = {1'b0, ~(4'b1000 >> d), SEG_T[msh[d]], ~mdp[3-d]};
    if (edge_no % (4 * PRESCALE) == 0) begin
      r[12]  = 1'b1;
      msh[0] = bus.A;
      msh[1] = bus.B;
      msh[2] = bus.C;
      msh[3] = bus.D;
      mdp    = bus.dp_in;
    end
    return r;
  endfunction

  task automatic set_digits(input logic [3:0] a, b, c, d, input logic [3:0] dpv);
    bus.A = a; bus.B = b; bus.C = c; bus.D = d; bus.dp_in = dpv;
  endtask

  task automatic test_reset();
    logic [12:0] e, got;
    for (int i = 0; i < 15; i++) begin
      if (i == 2)  rst = 1'b1;
      if (i == 7)  begin rst = 1'b0; set_digits(4'd9, 4'd9, 4'd9, 4'd9, 4'hF); end
      if (i == 10) begin rst = 1'b1; set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'h0); end
      @(posedge clk);
      exp_q.push_back(model_edge());
      #1;
      got = {bus.frame_tick, bus.an, bus.seg, bus.dp};
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL reset step=%0d edge=%0d got=%b want=%b", i, edge_no, got, e);
      end
    end
  endtask

  // Runs n checked edges; inputs may be changed by the caller between calls.
  task automatic test_scan(input int n);
    logic [12:0] e, got;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      exp_q.push_back(model_edge());
      #1;
      got = {bus.frame_tick, bus.an, bus.seg, bus.dp};
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL scan edge=%0d got=%b want=%b", edge_no, got, e);
      end
    end
  endtask

  task automatic test_coherence(input int n);
    logic [12:0] e, got;
    set_digits(4'd8, 4'd8, 4'd8, 4'd8, 4'h0);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      exp_q.push_back(model_edge());
      #1;
      got = {bus.frame_tick, bus.an, bus.seg, bus.dp};
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL coherence edge=%0d got=%b want=%b", edge_no, got, e);
      end
    end
  endtask

  task automatic test_invalid_dp_lzb(input logic [3:0] a, b, c, d, dpv, input int n);
    logic [12:0] e, got;
    set_digits(a, b, c, d, dpv);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      exp_q.push_back(model_edge());
      #1;
      got = {bus.frame_tick, bus.an, bus.seg, bus.dp};
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL pattern %h%h%h%h dp=%b edge=%0d got=%b want=%b",
                 a, b, c, d, dpv, edge_no, got, e);
      end
    end
  endtask

  task automatic test_back_to_back(input int n);
    logic [12:0] e, got;
    for (int i = 0; i < n; i++) begin
      if (i % 5 == 0)
        set_digits(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)));
      @(posedge clk);
      exp_q.push_back(model_edge());
      #1;
      got = {bus.frame_tick, bus.an, bus.seg, bus.dp};
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL back_to_back edge=%0d got=%b want=%b", edge_no, got, e);
      end
    end
  endtask

  initial begin
    set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'h0);
    for (int i = 0; i < 4; i++) msh[i] = 4'd0;
    mdp = 4'd0;
    test_reset();
    set_digits(4'd1, 4'd9, 4'd4, 4'd7, 4'h0);
    test_scan(37);
    test_coherence(32);
    test_invalid_dp_lzb(4'd8, 4'hC, 4'd8, 4'd8, 4'b0000, 56);
    test_invalid_dp_lzb(4'd8, 4'hC, 4'd8, 4'd8, 4'b0100, 32);
    test_invalid_dp_lzb(4'd0, 4'd0, 4'd5, 4'd0, 4'b0000, 64);
    test_invalid_dp_lzb(4'd0, 4'hB, 4'd0, 4'd3, 4'b1111, 64);
    test_back_to_back(96);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
